// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Pipeline interlock controller for a CPU datapath with RA_W-bit register
// addresses. A shift-register scoreboard records the destination register of
// every instruction issued past decode (entry 0 = EX, entry DEPTH-1 = last
// tracked stage). Decode-stage A/B operands are compared against the live
// entries; a match is a read-after-write hazard, which holds PC/IR and injects
// a bubble into EX until the producer shifts out of the tracked stages.
//
// Hold semantics: hazard, pc_hold, ir_hold and bubble are one combinational
// signal. While it is high the decode instruction is neither issued nor
// consumed; it is presented again next cycle and issues in the first cycle
// the signal is low. flush kills the decode instruction and overrides hazard.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   dec_valid             decode stage holds a valid instruction
//   dec_ma, dec_mb        1 = operand A/B does not read the register file
//   dec_aa, dec_ba        A/B source register addresses
//   dec_da, dec_rw        destination register and its write enable
//   flush                 branch taken: kill the decode instruction
//   hazard                combinational RAW hazard on decode operands
//   pc_hold, ir_hold      hold PC / IR this cycle
//   bubble                force RW=0, MW=0 into EX this cycle
//   ex_rw, ex_da          scoreboard entry 0 (instruction now in EX)
//   stall_cnt             saturating count of stall cycles since reset
//   stall_err             sticky: a stall ran longer than DEPTH cycles
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int RA_W  = 3,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    input  logic             dec_ma,
    input  logic             dec_mb,
    input  logic [RA_W-1:0]  dec_aa,
    input  logic [RA_W-1:0]  dec_ba,
    input  logic [RA_W-1:0]  dec_da,
    input  logic             dec_rw,
    input  logic             flush,
    output logic             hazard,
    output logic             pc_hold,
    output logic             ir_hold,
    output logic             bubble,
    output logic             ex_rw,
    output logic [RA_W-1:0]  ex_da,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             stall_err
);

    // Stall FSM encoding.
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    // run_len must be able to hold DEPTH+1 (its saturation value).
    localparam int              RL_W   = $clog2(DEPTH + 2);
    localparam logic [RL_W-1:0] RL_MAX = RL_W'(DEPTH);
    localparam logic [RL_W-1:0] RL_SAT = RL_W'(DEPTH + 1);

    // Scoreboard kept as packed vectors; entry k lives at bit k / slice k.
    logic [DEPTH-1:0]      sb_wr_q, sb_wr_d;
    logic [DEPTH*RA_W-1:0] sb_da_q, sb_da_d;

    logic [0:0]       state_q, state_d;
    logic [RL_W-1:0]  run_len_q, run_len_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall_err_q, stall_err_d;

    logic match;
    logic issue;

    // RAW detection. Register 0 is hard-wired, so an entry targeting it never
    // blocks a reader. An entry that has left the last stage is not checked:
    // the register file writes before it is read in the same cycle.
    always_comb begin
        match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (sb_wr_q[k] && (sb_da_q[k*RA_W +: RA_W] != '0)) begin
                if (!dec_ma && (dec_aa == sb_da_q[k*RA_W +: RA_W])) match = 1'b1;
                if (!dec_mb && (dec_ba == sb_da_q[k*RA_W +: RA_W])) match = 1'b1;
            end
        end
    end

    assign hazard  = dec_valid & ~flush & match;
    assign pc_hold = hazard;
    assign ir_hold = hazard;
    assign bubble  = hazard;
    assign issue   = dec_valid & ~hazard & ~flush;

    // Scoreboard shift. A bubble, a kill or an empty decode slot all enter
    // EX as {0, 0}.
    always_comb begin
        sb_wr_d = '0;
        sb_da_d = '0;
        if (issue) begin
            sb_wr_d[0]          = dec_rw;
            sb_da_d[RA_W-1:0]   = dec_da;
        end
        for (int k = 1; k < DEPTH; k++) begin
            sb_wr_d[k]              = sb_wr_q[k-1];
            sb_da_d[k*RA_W +: RA_W] = sb_da_q[(k-1)*RA_W +: RA_W];
        end
    end

    // Stall FSM and run-length tracking. A legal stall is bounded by DEPTH
    // cycles because every bubble pushes the producer one stage further; a
    // longer run means the scoreboard has been corrupted.
    always_comb begin
        state_d     = state_q;
        run_len_d   = run_len_q;
        stall_err_d = stall_err_q;
        if (flush) begin
            state_d   = ST_RUN;
            run_len_d = '0;
        end else if (hazard) begin
            state_d = ST_STALL;
            if (state_q == ST_RUN) begin
                run_len_d = RL_W'(1);
            end else begin
                if (run_len_q >= RL_MAX) stall_err_d = 1'b1;
                if (run_len_q != RL_SAT) run_len_d = run_len_q + RL_W'(1);
            end
        end else begin
            state_d   = ST_RUN;
            run_len_d = '0;
        end
    end

    // Stall statistics, saturating at all ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_wr_q     <= '0;
            sb_da_q     <= '0;
            state_q     <= ST_RUN;
            run_len_q   <= '0;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            sb_wr_q     <= sb_wr_d;
            sb_da_q     <= sb_da_d;
            state_q     <= state_d;
            run_len_q   <= run_len_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign ex_rw     = sb_wr_q[0];
    assign ex_da     = sb_da_q[RA_W-1:0];
    assign stall_cnt = stall_cnt_q;
    assign stall_err = stall_err_q;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline interlock controller for the 3-bit-register-address CPU datapath.
- Holds a scoreboard of destination registers for in-flight instructions downstream of decode and detects read-after-write hazards on the decode-stage A/B operands.
- Sequences stalls by holding PC/IR and injecting bubbles into execute; handles branch flush and keeps stall statistics.

Parameters:
- RA_W, 3, register address width (DA/AA/BA); register 0 is never a hazard source.
- DEPTH, 2, number of downstream stages tracked (EX..WB); legal 1 to 4.
- CNT_W, 16, width of stall cycle counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- dec_valid  input  1  decode stage holds a valid instruction
- dec_ma  input  1  1 = A operand is constant/PC, not register AA
- dec_mb  input  1  1 = B operand is immediate, not register BA
- dec_aa  input  RA_W  A source register
- dec_ba  input  RA_W  B source register
- dec_da  input  RA_W  destination register
- dec_rw  input  1  decode instruction writes register file
- flush  input  1  branch taken: kill the decode instruction this cycle
- hazard  output  1  combinational RAW hazard on decode operands
- pc_hold  output  1  hold PC this cycle
- ir_hold  output  1  hold IR/decode register this cycle
- bubble  output  1  force RW=0, MW=0 into EX this cycle
- ex_rw  output  1  registered write enable issued into EX (scoreboard entry 0)
- ex_da  output  RA_W  registered destination issued into EX
- stall_cnt  output  CNT_W  total stall cycles since reset, saturating
- stall_err  output  1  sticky: stall lasted more than DEPTH consecutive cycles

Behaviour:
- Scoreboard: DEPTH entries {wr, da}. Each cycle entry k+1 <= entry k. Entry 0 <= {dec_rw & dec_valid, dec_da} on issue, else {0, 0}.
- Issue occurs when dec_valid & !hazard & !flush.
- Live entry: wr=1 and da != 0.
- hazard = dec_valid & !flush & any live entry k with ((!dec_ma & dec_aa==da_k) | (!dec_mb & dec_ba==da_k)).
- pc_hold = ir_hold = bubble = hazard. All are combinational in the same cycle as the decode operands.
- flush: entry 0 loads {0, 0} (kill). flush has priority over hazard, so hazard=0 and no hold is asserted. Simultaneous flush and hazard counts as a flush, not a stall.
- dec_valid=0: entry 0 loads {0, 0}; no hazard, no hold.
- Stall length: because bubbles shift the producer out, one hazard clears within at most DEPTH cycles (producer in entry k clears after DEPTH-k cycles).
- FSM with states RUN and STALL:
  - RUN -> STALL when hazard=1; run_len <= 1.
  - STALL stays in STALL while hazard=1; run_len increments, saturating at DEPTH+1.
  - STALL -> RUN when hazard=0.
  - flush in any state -> RUN, clearing run_len.
- stall_err sets when run_len would exceed DEPTH. It is sticky until reset. It indicates a model error and must never fire under legal operation.
- stall_cnt increments on every cycle with hazard=1 and saturates at all ones (no wrap).
- Reset (async, any time including mid-stall):
  - All scoreboard entries {0, 0}; ex_rw=0, ex_da=0.
  - FSM RUN, run_len=0, stall_cnt=0, stall_err=0.
  - hazard/pc_hold/ir_hold/bubble=0 while in reset.
  - Bubbles in flight are discarded.
- Same-cycle writeback is not forwarded: an entry leaving the last stage is no longer tracked, because the register file write-before-read covers it.

Test Plan:
- Dependent pair, DEPTH=2: issue {rw=1, da=3}, next decode {ma=0, aa=3} -> hazard/pc_hold/bubble=1 for 2 cycles, then issue. stall_cnt=2, ex_rw sequence 1, 0, 0, 1.
- Register 0 and muxed operands: producer da=0 then aa=0 -> no stall. Producer da=5, consumer ba=5 with mb=1 -> no stall. With mb=0 -> stall, distance-1 consumer stalls 2 cycles.
- Distance-2 dependence: producer da=4, one independent instruction, then aa=4 consumer -> exactly 1 stall cycle; stall_cnt=1.
- Flush during stall: hazard active on cycle 1, flush=1 on cycle 2 -> hazard=0 that cycle, ex_rw=0, FSM RUN. stall_cnt=1, stall_err=0.
- Reset mid-stall: assert rst_n=0 asynchronously while bubble=1 -> all outputs 0 immediately. After release, first decode aa=3 with no producers -> no stall.
- Saturation: CNT_W=2, force 5 stall cycles via repeated dependent pairs -> stall_cnt holds at 3. Drive hazard stimulus violating the model (scoreboard forced) -> stall_err=1 and stays 1.
